add_serial: RTL and testbench
=============================

# add_serial

Digit-serial successor to the combinational width-extending adder: adds an N-bit operand A to an M-bit operand B (M ≤ N), W bits per clock, and produces the full N+1-bit result without overflow. Signed or unsigned extension is chosen per operation. Used in sequential garbled-circuit datapaths where a full N-bit carry chain per cycle costs too many gates. A start/busy/done handshake frames each operation.

## Interface
- N, default 8: width of A; must be a multiple of W.
- M, default N: width of B; 1 ≤ M ≤ N.
- W, default 2: digit width processed per cycle; 1 ≤ W ≤ N.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- sgn  in  1  1 = signed (sign-extend B), 0 = unsigned (zero-extend B); captured with start.
- A  in  N  operand A; captured with start.
- B  in  M  operand B; captured with start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when O is valid.
- O  out  N+1  result; holds its value until the next accepted start.

## Operation
- States: IDLE, RUN, DONE. Reset leads to IDLE.
- IDLE or DONE with start=1: capture A and BB, where BB is B extended to N bits (sign-extended if sgn=1, zero-extended if sgn=0). Also capture sgn, clear carry, clear the digit counter, clear O, and go to RUN.
- IDLE or DONE with start=0: DONE goes to IDLE, and IDLE stays in IDLE.
- RUN, each cycle:
  - digit sum = A_reg[W-1:0] + BB_reg[W-1:0] + carry (W+1 bits).
  - The low W bits shift into O[N-1:0] from the top, so the LSB digit lands lowest after D shifts.
  - The carry register takes bit W. A_reg and BB_reg shift right by W.
- D = N/W digits. After the D-th RUN cycle, go to DONE.
- MSB on entry to DONE, with CO = final carry:
  - Unsigned: O[N] = CO.
  - Signed: O[N] = A[N-1] ^ BB[N-1] ^ CO, using the captured MSBs.
- start while busy=1 is ignored and has no side effects. The operands are registered, so input changes after capture have no effect.
- Reset at any time, including mid-RUN: state goes to IDLE, and O, done, busy, carry and counter all go to 0. The aborted operation produces no done.

## Timing
- Reset values: O=0, busy=0, done=0.
- start accepted at edge k:
  - busy=1 from edge k to edge k+D.
  - done=1 and O valid from edge k+D to edge k+D+1.
- Latency is D+1 cycles from accepting start to done deasserting. Throughput is one operation per D+1 cycles with back-to-back start in DONE; otherwise D+2.
- The partially shifted O is visible during RUN. It is only meaningful when done=1 and afterwards.

## Configuration
- ADD_SERIAL_SUB_EN defined:
  - Adds input port sub (1 bit), captured with start.
  - When sub=1, BB is replaced by ~BB and the initial carry is 1, giving A − B.
  - Unsigned O[N] = ~CO, so 9-bit two's-complement results wrap correctly.
  - Signed O[N] uses the inverted captured BB[N-1].
- ADD_SERIAL_SUB_EN undefined: no sub port; addition only; behaviour exactly as above.

## Structure
- Package add_serial_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a constant function for digit count D and counter width $clog2(D+1);
  - an elaboration check function enforcing N%W==0 and M≤N.
- One sub-module, add_digit: W-bit ripple adder with ports A, B, CI, S, CO. It is instantiated once and reused every cycle.

## Test plan
All scenarios use N=8, M=4, W=2, so D=4.
- Unsigned add: sgn=0, A=8'hFF, B=4'hF, start pulse. Required: O=9'h10E, done exactly 4 edges after the accepting edge, busy high for 4 cycles.
- Signed negative extremes: sgn=1, A=8'h80, B=4'hF. Required: O=9'h17F (−129).
- Signed positive overflow into O[N]: sgn=1, A=8'h7F, B=4'h1. Required: O=9'h080 (+128).
- Start while busy, then reset:
  - Pulse start again at RUN cycle 2 with different operands. Required: ignored, result of the first operation unaffected.
  - Repeat the operation and assert rst during RUN cycle 2. Required: O=0, busy=0, done=0 immediately, and no done pulse.
  - Next operation A=8'h01, B=4'h1 unsigned. Required: O=9'h002.
- Back-to-back: assert start during the DONE cycle with A=8'h10, B=4'h2, sgn=0. Required: accepted, next done exactly D+1 cycles after the previous done, O=9'h012.
- With ADD_SERIAL_SUB_EN, sub=1, A=8'h05, B=4'h7:
  - sgn=1 gives O=9'h1FE.
  - sgn=0 gives O=9'h1FE (borrow in O[N]).

Source files
------------

// File: rtl/add_serial_pkg.sv
// add_serial_pkg
// Shared types and elaboration-time helpers for the digit-serial adder.
//   state_t       : controller states (IDLE, RUN, DONE)
//   digit_count   : number of W-bit digits in an N-bit operand
//   count_width   : width of a counter that can hold 0..digit_count
//   params_ok     : legality of the N/M/W parameter combination
package add_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int digit_count(input int n, input int w);
      return n / w;
   endfunction

   function automatic int count_width(input int n, input int w);
      return $clog2(n / w + 1);
   endfunction

   function automatic bit params_ok(input int n, input int m, input int w);
      return (w >= 1) && (w <= n) && ((n % w) == 0) && (m >= 1) && (m <= n);
   endfunction

endpackage

// File: rtl/add_serial_if.sv
// add_serial_if
// Operation request / result bundle of the digit-serial adder.
//   start, sgn, A (N bits), B (M bits) : request side, driven by the master
//   sub                                : subtract request (only with ADD_SERIAL_SUB_EN)
//   busy, done, O (N+1 bits)           : status and result, driven by the slave
interface add_serial_if #(
   parameter int N = 8,
   parameter int M = N
);
   logic         start;
   logic         sgn;
   logic [N-1:0] A;
   logic [M-1:0] B;
`ifdef ADD_SERIAL_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [N:0]   O;

`ifdef ADD_SERIAL_SUB_EN
   modport master (output start, sgn, A, B, sub, input busy, done, O);
   modport slave  (input start, sgn, A, B, sub, output busy, done, O);
`else
   modport master (output start, sgn, A, B, input busy, done, O);
   modport slave  (input start, sgn, A, B, output busy, done, O);
`endif
endinterface

// File: rtl/add_serial_add_digit.sv
// add_digit
// W-bit ripple-carry adder used once per clock by add_serial.
//   A, B : W-bit addends
//   CI   : carry in
//   S    : W-bit sum
//   CO   : carry out of the top bit
module add_digit #(
   parameter int W = 2
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         CI,
   output logic [W-1:0] S,
   output logic         CO
);

   // Explicit bit-by-bit ripple so the gate count stays linear in W.
   always_comb begin
      logic [W:0] c;
      c    = '0;
      S    = '0;
      c[0] = CI;
      for (int i = 0; i < W; i++) begin
         S[i]   = A[i] ^ B[i] ^ c[i];
         c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
      end
      CO = c[W];
   end

endmodule

// File: rtl/add_serial.sv
// add_serial
// Digit-serial width-extending adder: O = A + ext(B) as an N+1-bit result,
// W bits per clock, D = N/W clocks per operation.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : add_serial_if.slave (start/sgn/A/B[/sub] in, busy/done/O out)
// Optional feature macro: ADD_SERIAL_SUB_EN adds a sub input selecting A - B.
module add_serial
   import add_serial_pkg::*;
#(
   parameter int N = 8,
   parameter int M = N,
   parameter int W = 2
) (
   input logic         clk,
   input logic         rst,
   add_serial_if.slave bus
);

   localparam int D  = digit_count(N, W);
   localparam int CW = count_width(N, W);

   generate
      if (!params_ok(N, M, W)) begin : g_bad_params
         $error("add_serial: illegal parameters (need N %% W == 0, 1 <= M <= N, 1 <= W <= N)");
      end
   endgenerate

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   a_reg;
   logic [N-1:0]   bb_reg;
   logic [N-1:0]   bb_ext;
   logic [N-1:0]   bb_cap;
   logic [N-1:0]   o_low_next;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   dsum;
   logic           dco;
   logic           carry;
   logic           carry_init;
   logic           a_msb;
   logic           bb_msb;
   logic           sgn_reg;
   logic           accept;
   logic           last_digit;
   logic           msb_out;
`ifdef ADD_SERIAL_SUB_EN
   logic           sub_reg;
`endif

   add_digit #(.W(W)) u_digit (
      .A  (a_reg[W-1:0]),
      .B  (bb_reg[W-1:0]),
      .CI (carry),
      .S  (dsum),
      .CO (dco)
   );

   // Extend B to N bits; subtraction feeds the inverted operand with a
   // carry-in of one so the same adder computes A + ~BB + 1.
   always_comb begin
      bb_ext         = '0;
      bb_ext[M-1:0]  = bus.B;
      for (int i = M; i < N; i++) begin
         bb_ext[i] = bus.B[M-1] & bus.sgn;
      end
`ifdef ADD_SERIAL_SUB_EN
      bb_cap     = bus.sub ? ~bb_ext : bb_ext;
      carry_init = bus.sub;
`else
      bb_cap     = bb_ext;
      carry_init = 1'b0;
`endif
   end

   // Request acceptance, last-digit detect and the result MSB. The signed MSB
   // is the sign bit of the (N+1)-bit sum of the sign-extended operands.
   always_comb begin
      accept     = bus.start && (state != RUN);
      last_digit = (cnt == CW'(D - 1));
      o_low_next = (bus.O[N-1:0] >> W) | (N'(dsum) << (N - W));
`ifdef ADD_SERIAL_SUB_EN
      msb_out    = sgn_reg ? (a_msb ^ bb_msb ^ dco) : (dco ^ sub_reg);
`else
      msb_out    = sgn_reg ? (a_msb ^ bb_msb ^ dco) : dco;
`endif
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = accept ? RUN : IDLE;
         RUN:     state_next = last_digit ? DONE : RUN;
         DONE:    state_next = accept ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs are pure decodes of the state.
   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end

   // Datapath: capture on accept, then one digit per RUN cycle. Sum digits
   // enter O from the top so the first (least significant) digit ends lowest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         bb_reg  <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         a_msb   <= 1'b0;
         bb_msb  <= 1'b0;
         sgn_reg <= 1'b0;
`ifdef ADD_SERIAL_SUB_EN
         sub_reg <= 1'b0;
`endif
         bus.O   <= '0;
      end else if (accept) begin
         a_reg   <= bus.A;
         bb_reg  <= bb_cap;
         carry   <= carry_init;
         cnt     <= '0;
         a_msb   <= bus.A[N-1];
         bb_msb  <= bb_cap[N-1];
         sgn_reg <= bus.sgn;
`ifdef ADD_SERIAL_SUB_EN
         sub_reg <= bus.sub;
`endif
         bus.O   <= '0;
      end else if (state == RUN) begin
         a_reg          <= a_reg >> W;
         bb_reg         <= bb_reg >> W;
         carry          <= dco;
         cnt            <= cnt + CW'(1);
         bus.O[N-1:0]   <= o_low_next;
         if (last_digit) begin
            bus.O[N] <= msb_out;
         end
      end
   end

endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial
// Self-checking bench for add_serial (N=8, M=4, W=2). A cycle-level reference
// tracks when busy/done must be high and what O must hold, with results taken
// from plain integer arithmetic. Directed cases pin literal values.
module tb_add_serial;

   localparam int N = 8;
   localparam int M = 4;
   localparam int W = 2;
   localparam int D = N / W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic mon_en = 1'b0;

   int check_count = 0;
   int pass_count  = 0;

   int         phase     = 0;
   logic [N:0] held_o    = '0;
   logic [N:0] pending_o = '0;

   always #5 clk = ~clk;

   add_serial_if #(.N(N), .M(M)) bus ();

   add_serial #(.N(N), .M(M), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Mathematical result: operands as integers, exact sum/difference, 9-bit wrap.
   function automatic logic [N:0] ref_result(input logic [N-1:0] a, input logic [M-1:0] b,
                                             input logic s, input logic sb);
      int av;
      int bv;
      int r;
      av = s ? int'($signed(a)) : int'(a);
      bv = s ? int'($signed(b)) : int'(b);
      r  = sb ? (av - bv) : (av + bv);
      return r[N:0];
   endfunction

   function automatic logic cur_sub();
`ifdef ADD_SERIAL_SUB_EN
      return bus.sub;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_value(input string name, input logic [N:0] actual, input logic [N:0] required);
      check_count++;
      if (actual === required) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %h, required %h at %0t", name, actual, required, $time);
      end
   endtask

   // Reference timeline: phase 0 idle, 1..D busy cycles, D+1 result cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         phase  <= 0;
         held_o <= '0;
      end else if (phase == 0 || phase == D + 1) begin
         if (bus.start === 1'b1) begin
            pending_o <= ref_result(bus.A, bus.B, bus.sgn, cur_sub());
            phase     <= 1;
         end else begin
            phase <= 0;
         end
      end else begin
         if (phase == D) begin
            held_o <= pending_o;
         end
         phase <= phase + 1;
      end
   end

   // Every-cycle comparison against the reference timeline.
   always @(negedge clk) begin
      if (mon_en) begin
         check_value("busy", {8'd0, bus.busy}, {8'd0, (phase >= 1 && phase <= D)});
         check_value("done", {8'd0, bus.done}, {8'd0, (phase == D + 1)});
         if (phase == 0 || phase == D + 1) begin
            check_value("O_cycle", bus.O, held_o);
         end
      end
   end

   task automatic apply_stimulus(input logic [N-1:0] a, input logic [M-1:0] b,
                                 input logic s, input logic sb);
      bus.A   = a;
      bus.B   = b;
      bus.sgn = s;
`ifdef ADD_SERIAL_SUB_EN
      bus.sub = sb;
`else
      if (sb) $display("[TB] note: sub requested without subtract support");
`endif
   endtask

   // Called at a negedge with the DUT idle or done; returns at the negedge
   // where done is seen. Optionally pokes start again during RUN cycle 2.
   task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b, input logic s,
                         input logic sb, input bit poke,
                         output int edges, output int busy_cnt);
      bit timed_out;
      apply_stimulus(a, b, s, sb);
      bus.start = 1'b1;
      edges     = 0;
      busy_cnt  = 0;
      timed_out = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) bus.start = 1'b0;
         if (poke && i == 1) begin
            apply_stimulus(~a, ~b, ~s, 1'b0);
            bus.start = 1'b1;
         end
         if (poke && i == 2) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
         if (bus.busy === 1'b1) busy_cnt++;
         @(posedge clk);
         edges++;
      end
      check_value("done_within_bound", {8'd0, timed_out}, 9'd0);
   endtask

   task automatic check_output(input string name, input logic [N-1:0] a, input logic [M-1:0] b,
                               input logic s, input logic sb, input bit poke,
                               input bit use_lit, input logic [N:0] lit);
      int edges;
      int busy_cnt;
      run_op(a, b, s, sb, poke, edges, busy_cnt);
      check_value({name, "_latency"}, 9'(edges), 9'(D));
      check_value({name, "_busy_cycles"}, 9'(busy_cnt), 9'(D));
      check_value({name, "_O_ref"}, bus.O, ref_result(a, b, s, sb));
      if (use_lit) check_value({name, "_O_literal"}, bus.O, lit);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int  edges;
      int  busy_cnt;
      bit  saw_done;
      logic [N-1:0] ra;
      logic [M-1:0] rb;
      logic rs;
      logic rsb;

      bus.start = 1'b0;
      apply_stimulus('0, '0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      check_value("reset_O", bus.O, 9'h000);
      check_value("reset_busy", {8'd0, bus.busy}, 9'd0);
      check_value("reset_done", {8'd0, bus.done}, 9'd0);
      rst = 1'b0;
      @(negedge clk);

      check_output("unsigned_max", 8'hFF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 9'h10E);
      @(negedge clk);
      check_output("signed_neg", 8'h80, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 9'h17F);
      @(negedge clk);
      check_output("signed_pos", 8'h7F, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h080);
      @(negedge clk);

      // Second start during RUN must be ignored: 0x12 + 0x3 = 0x015.
      check_output("start_while_busy", 8'h12, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 9'h015);
      @(negedge clk);

      // Same operation aborted by reset in RUN cycle 2.
      apply_stimulus(8'h12, 4'h3, 1'b0, 1'b0);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_value("abort_O", bus.O, 9'h000);
      check_value("abort_busy", {8'd0, bus.busy}, 9'd0);
      check_value("abort_done", {8'd0, bus.done}, 9'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check_value("abort_no_done", {8'd0, saw_done}, 9'd0);

      check_output("after_abort", 8'h01, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h002);

      // Back-to-back: start asserted in the DONE cycle of the previous op.
      run_op(8'h10, 4'h2, 1'b0, 1'b0, 1'b0, edges, busy_cnt);
      check_value("b2b_done_spacing", 9'(edges + 1), 9'(D + 1));
      check_value("b2b_O_literal", bus.O, 9'h012);
      @(negedge clk);

`ifdef ADD_SERIAL_SUB_EN
      check_output("sub_signed", 8'h05, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 9'h1FE);
      @(negedge clk);
      check_output("sub_unsigned", 8'h05, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1FE);
      @(negedge clk);
`endif

      // Randomized operations with random idle gaps (zero gap = back-to-back).
      for (int k = 0; k < 40; k++) begin
         ra  = N'($urandom);
         rb  = M'($urandom);
         rs  = 1'($urandom_range(0, 1));
`ifdef ADD_SERIAL_SUB_EN
         rsb = 1'($urandom_range(0, 1));
`else
         rsb = 1'b0;
`endif
         check_output("random", ra, rb, rs, rsb, 1'($urandom_range(0, 1)), 1'b0, 9'h000);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
